// File: rtl/execute_stage.sv
// Execute slice of the 16-bit scalar pipeline: decode/execute register, ALU and
// execute/memory register. The unregistered ALU result is exported for forwarding.
module execute_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OPW   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPW-1:0]   aluOp_in,
  input  logic [WIDTH-1:0] srcA_in,
  input  logic [WIDTH-1:0] srcB_in,
  output logic [OPW-1:0]   aluOp_execute,
  output logic [WIDTH-1:0] srcA_execute,
  output logic [WIDTH-1:0] srcB_execute,
  output logic [WIDTH-1:0] alu_result_execute,
  output logic [WIDTH-1:0] alu_result_memory,
  output logic [3:0]       flags_memory
);

  localparam int unsigned ShW = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OpAdd   = 4'd0,
    OpSub   = 4'd1,
    OpAnd   = 4'd2,
    OpOr    = 4'd3,
    OpXor   = 4'd4,
    OpNot   = 4'd5,
    OpSll   = 4'd6,
    OpSrl   = 4'd7,
    OpSra   = 4'd8,
    OpMul   = 4'd9,
    OpPassA = 4'd10,
    OpPassB = 4'd11,
    OpSlt   = 4'd12,
    OpSltu  = 4'd13,
    OpRsv0  = 4'd14,
    OpRsv1  = 4'd15
  } alu_op_e;

  // Decode/execute pipeline register
  logic [OPW-1:0]   aluop_d, aluop_q;
  logic [WIDTH-1:0] srca_d, srca_q;
  logic [WIDTH-1:0] srcb_d, srcb_q;

  // Execute/memory pipeline register
  logic [WIDTH-1:0] result_d, result_q;
  logic [3:0]       flags_d, flags_q;

  // ALU internals
  alu_op_e          op;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [ShW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             flag_n, flag_z, flag_c, flag_v;
  logic             add_ovf, sub_ovf;
  logic             slt_res;

  always_comb begin
    aluop_d = aluOp_in;
    srca_d  = srcA_in;
    srcb_d  = srcB_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aluop_q <= '0;
      srca_q  <= '0;
      srcb_q  <= '0;
    end else begin
      aluop_q <= aluop_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
    end
  end

  assign op    = alu_op_e'(aluop_q[3:0]);
  assign shamt = srcb_q[ShW-1:0];

  // Extra top bit holds the carry for ADD and the borrow for SUB.
  assign sum_ext  = {1'b0, srca_q} + {1'b0, srcb_q};
  assign diff_ext = {1'b0, srca_q} - {1'b0, srcb_q};

  assign add_ovf = (srca_q[WIDTH-1] == srcb_q[WIDTH-1]) &&
                   (sum_ext[WIDTH-1] != srca_q[WIDTH-1]);
  assign sub_ovf = (srca_q[WIDTH-1] != srcb_q[WIDTH-1]) &&
                   (diff_ext[WIDTH-1] != srca_q[WIDTH-1]);
  assign slt_res = $signed(srca_q) < $signed(srcb_q);

  always_comb begin
    alu_res = '0;
    unique case (op)
      OpAdd:   alu_res = sum_ext[WIDTH-1:0];
      OpSub:   alu_res = diff_ext[WIDTH-1:0];
      OpAnd:   alu_res = srca_q & srcb_q;
      OpOr:    alu_res = srca_q | srcb_q;
      OpXor:   alu_res = srca_q ^ srcb_q;
      OpNot:   alu_res = ~srca_q;
      OpSll:   alu_res = srca_q << shamt;
      OpSrl:   alu_res = srca_q >> shamt;
      OpSra:   alu_res = WIDTH'($signed(srca_q) >>> shamt);
      OpMul:   alu_res = srca_q * srcb_q;
      OpPassA: alu_res = srca_q;
      OpPassB: alu_res = srcb_q;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, slt_res};
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
      OpRsv0,
      OpRsv1:  alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    flag_n = alu_res[WIDTH-1];
    flag_z = (alu_res == '0);
    flag_c = 1'b0;
    flag_v = 1'b0;
    if (op == OpAdd) begin
      flag_c = sum_ext[WIDTH];
      flag_v = add_ovf;
    end else if (op == OpSub) begin
      flag_c = diff_ext[WIDTH];
      flag_v = sub_ovf;
    end
  end

  always_comb begin
    result_d = alu_res;
    flags_d  = {flag_n, flag_z, flag_c, flag_v};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign aluOp_execute      = aluop_q;
  assign srcA_execute       = srca_q;
  assign srcB_execute       = srcb_q;
  assign alu_result_execute = alu_res;
  assign alu_result_memory  = result_q;
  assign flags_memory       = flags_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: integer-arithmetic reference model checked on every
// cycle, plus hand-computed literal pins and randomized traffic with resets.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] aluop_in, srca_in, srcb_in;
  logic [15:0] aluop_ex, srca_ex, srcb_ex;
  logic [15:0] res_ex, res_mem;
  logic [3:0]  flags_mem;

  execute_stage #(
    .WIDTH(16),
    .OPW  (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .aluOp_in          (aluop_in),
    .srcA_in           (srca_in),
    .srcB_in           (srcb_in),
    .aluOp_execute     (aluop_ex),
    .srcA_execute      (srca_ex),
    .srcB_execute      (srcb_ex),
    .alu_result_execute(res_ex),
    .alu_result_memory (res_mem),
    .flags_memory      (flags_mem)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model of what each pipeline stage must hold
  logic [15:0] m_op, m_a, m_b, m_res;
  logic [3:0]  m_flags;

  // Returns {N,Z,C,V, result} from plain integer arithmetic.
  function automatic logic [19:0] ref_alu(input logic [15:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    int     ua, ub, sa, sb, n;
    longint r;
    bit     c, v;
    logic [15:0] res;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    n  = ub % 16;
    r  = 0;
    c  = 1'b0;
    v  = 1'b0;
    case (int'(op[3:0]))
      0: begin r = ua + ub; c = (r > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
      1: begin r = ua - ub; c = (ua < ub);   v = (sa - sb > 32767) || (sa - sb < -32768); end
      2: r = ua & ub;
      3: r = ua | ub;
      4: r = ua ^ ub;
      5: r = 65535 - ua;
      6: r = longint'(ua) * (longint'(1) << n);
      7: r = ua / (1 << n);
      8: r = sa >>> n;
      9: r = longint'(ua) * longint'(ub);
      10: r = ua;
      11: r = ub;
      12: r = (sa < sb) ? 1 : 0;
      13: r = (ua < ub) ? 1 : 0;
      default: r = 0;
    endcase
    res = r[15:0];
    return {res[15], (res == 16'h0), c, v, res};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [19:0] e;
    if (cmp_en) begin
      e = ref_alu(m_op, m_a, m_b);
      chk("op_execute", aluop_ex, m_op);
      chk("srcA_execute", srca_ex, m_a);
      chk("srcB_execute", srcb_ex, m_b);
      chk("result_execute", res_ex, e[15:0]);
      chk("result_memory", res_mem, m_res);
      chk("flags_memory", {12'h0, flags_mem}, {12'h0, m_flags});
    end
  end

  task automatic step(input bit r, input logic [15:0] op, input logic [15:0] a,
                      input logic [15:0] b);
    logic [19:0] e;
    reset    = r;
    aluop_in = op;
    srca_in  = a;
    srcb_in  = b;
    @(posedge clk);
    if (r) begin
      m_op = '0; m_a = '0; m_b = '0; m_res = '0; m_flags = '0;
    end else begin
      e       = ref_alu(m_op, m_a, m_b);
      m_res   = e[15:0];
      m_flags = e[19:16];
      m_op    = op;
      m_a     = a;
      m_b     = b;
    end
    #1;
  endtask

  function automatic logic [15:0] pick_operand();
    logic [15:0] edges [5];
    edges = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    if ($urandom_range(3) == 0) return edges[$urandom_range(4)];
    return 16'($urandom);
  endfunction

  typedef struct {
    logic [15:0] op, a, b, res;
    logic [3:0]  flags;
  } pin_t;

  pin_t pins [14];

  initial begin
    pins = '{
      '{16'd0,  16'd5,     16'd3,     16'h0008, 4'b0000},
      '{16'd1,  16'd3,     16'd5,     16'hFFFE, 4'b1010},
      '{16'd1,  16'd7,     16'd7,     16'h0000, 4'b0100},
      '{16'd0,  16'h7FFF,  16'h0001,  16'h8000, 4'b1001},
      '{16'd0,  16'hFFFF,  16'h0001,  16'h0000, 4'b0110},
      '{16'd6,  16'h0001,  16'h0013,  16'h0008, 4'b0000},
      '{16'd8,  16'h8000,  16'h0004,  16'hF800, 4'b1000},
      '{16'd7,  16'h8000,  16'h0004,  16'h0800, 4'b0000},
      '{16'd9,  16'h0100,  16'h0100,  16'h0000, 4'b0100},
      '{16'd12, 16'hFFFF,  16'h0001,  16'h0001, 4'b0000},
      '{16'd13, 16'hFFFF,  16'h0001,  16'h0000, 4'b0100},
      '{16'hF000, 16'd2,   16'd3,     16'h0005, 4'b0000},
      '{16'd5,  16'h00FF,  16'h1234,  16'hFF00, 4'b1000},
      '{16'd14, 16'h1234,  16'h5678,  16'h0000, 4'b0100}
    };

    // Reset held two cycles with random inputs
    step(1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
    cmp_en = 1'b1;
    step(1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
    chk("reset_op", aluop_ex, 16'h0);
    chk("reset_result_ex", res_ex, 16'h0);
    chk("reset_result_mem", res_mem, 16'h0);
    chk("reset_flags", {12'h0, flags_mem}, 16'h0);
    step(1'b0, 16'h0, 16'h0, 16'h0);
    chk("release_result_ex", res_ex, 16'h0);
    chk("release_result_mem", res_mem, 16'h0);

    // Literal pins, issued back to back; each result checked after 1 and 2 edges
    for (int i = 0; i <= 14; i++) begin
      if (i < 14) step(1'b0, pins[i].op, pins[i].a, pins[i].b);
      else        step(1'b0, 16'h0, 16'h0, 16'h0);
      if (i < 14) chk($sformatf("pin%0d_result_ex", i), res_ex, pins[i].res);
      if (i >= 1) begin
        chk($sformatf("pin%0d_result_mem", i - 1), res_mem, pins[i-1].res);
        chk($sformatf("pin%0d_flags", i - 1), {12'h0, flags_mem}, {12'h0, pins[i-1].flags});
      end
    end

    // Reset right behind an ADD 1+1 must discard it
    step(1'b0, 16'd0, 16'd1, 16'd1);
    chk("midreset_ex", res_ex, 16'h0002);
    step(1'b1, 16'($urandom), 16'($urandom), 16'($urandom));
    chk("midreset_mem0", res_mem, 16'h0);
    step(1'b0, 16'h0, 16'h0, 16'h0);
    chk("midreset_mem1", res_mem, 16'h0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] op;
      op = 16'($urandom);
      if ($urandom_range(1) == 0) op = {op[15:4], 4'($urandom_range(15))};
      step(($urandom_range(60) == 0), op, pick_operand(), pick_operand());
    end

    step(1'b0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
